// File: rtl/hazard_pipe_ctrl.sv
// hazard_pipe_ctrl
// Pipeline-control block for the 5-stage MIPS core. It holds the register-tag
// fields of the ID/EX, EX/M and M/WB pipeline registers, which feed the
// forwarding unit. It also detects load-use hazards that forwarding cannot
// cover, and handles them by holding PC and IF/ID while bubbles are injected
// into ID/EX. A taken branch squashes IF/ID and ID/EX.
//
// Optional feature: define HAZ_STALL_CNT_EN to add the stall_cnt port. This is
// a saturating 16-bit count of cycles in which PC was held.
//
// LOAD_STALL sets the number of bubbles inserted per load-use hazard. The
// legal range is 1..7; values above 1 model a slow data memory.

module hazard_pipe_ctrl #(
    parameter int LOAD_STALL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_valid,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_RegWrite,
    input  logic        ID_MemRead,
    input  logic [4:0]  ID_WR,
    input  logic        flush,
    output logic [4:0]  EX_Rs,
    output logic [4:0]  EX_Rt,
    output logic        EX_RegWrite,
    output logic        EX_MemRead,
    output logic [4:0]  EX_WR,
    output logic        M_RegWrite,
    output logic [4:0]  M_WR_out,
    output logic        WB_RegWrite,
    output logic [4:0]  WB_WR_out,
    output logic        PC_stall,
    output logic        IFID_stall,
    output logic        IFID_flush
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // The hazard cycle itself is one bubble, so the counter starts one lower.
    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic [2:0] cnt_nxt;

    logic       hazard;
    logic       stall_req;
    logic       bubble;

    logic [4:0] idex_rs_nxt;
    logic [4:0] idex_rt_nxt;
    logic       idex_regwrite_nxt;
    logic       idex_memread_nxt;
    logic [4:0] idex_wr_nxt;

    // A load in EX whose destination is read by the instruction in ID.
    // r0 is never a real dependency.
    assign hazard = ID_valid & EX_MemRead & (EX_WR != 5'd0) &
                    ((EX_WR == ID_Rs) | (EX_WR == ID_Rt));

    // Next-state logic for the stall sequencer. A flush always wins and
    // drops back to RUN, because the dependent instruction is squashed.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_req = 1'b0;
        unique case (state)
            RUN: begin
                if (hazard) begin
                    stall_req = 1'b1;
                    if (!flush) begin
                        state_nxt = STALL;
                        cnt_nxt   = STALL_INIT;
                    end
                end
            end
            STALL: begin
                if (cnt != 3'd0) begin
                    stall_req = 1'b1;
                    cnt_nxt   = cnt - 3'd1;
                end else begin
                    state_nxt = RUN;
                end
                if (flush) begin
                    state_nxt = RUN;
                    cnt_nxt   = 3'd0;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    assign bubble     = flush | stall_req;
    assign PC_stall   = stall_req & ~flush;
    assign IFID_stall = stall_req & ~flush;
    assign IFID_flush = flush;

    // ID/EX next value. This is either the decoded ID fields or a bubble.
    // A write to r0 is neutralised here so nothing downstream forwards it.
    always_comb begin
        idex_rs_nxt       = 5'd0;
        idex_rt_nxt       = 5'd0;
        idex_regwrite_nxt = 1'b0;
        idex_memread_nxt  = 1'b0;
        idex_wr_nxt       = 5'd0;
        if (!bubble && ID_valid) begin
            idex_rs_nxt       = ID_Rs;
            idex_rt_nxt       = ID_Rt;
            idex_regwrite_nxt = ID_RegWrite & (ID_WR != 5'd0);
            idex_memread_nxt  = ID_MemRead;
            idex_wr_nxt       = ID_WR;
        end
    end

    // Stall sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Pipeline tag registers. EX/M and M/WB shift every cycle without stalling.
    always_ff @(posedge clk) begin
        if (!rst) begin
            EX_Rs       <= 5'd0;
            EX_Rt       <= 5'd0;
            EX_RegWrite <= 1'b0;
            EX_MemRead  <= 1'b0;
            EX_WR       <= 5'd0;
            M_RegWrite  <= 1'b0;
            M_WR_out    <= 5'd0;
            WB_RegWrite <= 1'b0;
            WB_WR_out   <= 5'd0;
        end else begin
            EX_Rs       <= idex_rs_nxt;
            EX_Rt       <= idex_rt_nxt;
            EX_RegWrite <= idex_regwrite_nxt;
            EX_MemRead  <= idex_memread_nxt;
            EX_WR       <= idex_wr_nxt;
            M_RegWrite  <= EX_RegWrite;
            M_WR_out    <= EX_WR;
            WB_RegWrite <= M_RegWrite;
            WB_WR_out   <= M_WR_out;
        end
    end

`ifdef HAZ_STALL_CNT_EN
    // Saturating count of cycles in which PC was held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= 16'd0;
        end else if (PC_stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Testbench for hazard_pipe_ctrl.
// Two instances share one set of inputs: one with LOAD_STALL=1 and one with
// LOAD_STALL=3. Each stimulus cycle queues the hand-computed expected outputs
// for one instance. The negedge monitor then pops and compares them.
// stall_cnt is checked when HAZ_STALL_CNT_EN is defined.

module tb_hazard_pipe_ctrl;

    logic       clk;
    logic       rst;
    logic       ID_valid;
    logic [4:0] ID_Rs;
    logic [4:0] ID_Rt;
    logic       ID_RegWrite;
    logic       ID_MemRead;
    logic [4:0] ID_WR;
    logic       flush;

    logic [4:0] ex_rs1, ex_rt1, ex_wr1, m_wr1, wb_wr1;
    logic       ex_rw1, ex_mr1, m_rw1, wb_rw1, pc_st1, ifid_st1, ifid_fl1;
    logic [4:0] ex_rs3, ex_rt3, ex_wr3, m_wr3, wb_wr3;
    logic       ex_rw3, ex_mr3, m_rw3, wb_rw3, pc_st3, ifid_st3, ifid_fl3;
`ifdef HAZ_STALL_CNT_EN
    logic [15:0] cnt1;
    logic [15:0] cnt3;
`endif

    typedef struct {
        string       name;
        bit          sel3;
        bit          chk;
        logic [31:0] expv;
        logic [15:0] exp_cnt;
    } entry_t;

    entry_t sb[$];
    int     tests_run = 0;
    int     tests_failed = 0;

    hazard_pipe_ctrl #(.LOAD_STALL(1)) dut1 (
        .clk(clk), .rst(rst), .ID_valid(ID_valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_WR(ID_WR), .flush(flush),
        .EX_Rs(ex_rs1), .EX_Rt(ex_rt1), .EX_RegWrite(ex_rw1), .EX_MemRead(ex_mr1), .EX_WR(ex_wr1),
        .M_RegWrite(m_rw1), .M_WR_out(m_wr1), .WB_RegWrite(wb_rw1), .WB_WR_out(wb_wr1),
        .PC_stall(pc_st1), .IFID_stall(ifid_st1), .IFID_flush(ifid_fl1)
`ifdef HAZ_STALL_CNT_EN
        , .stall_cnt(cnt1)
`endif
    );

    hazard_pipe_ctrl #(.LOAD_STALL(3)) dut3 (
        .clk(clk), .rst(rst), .ID_valid(ID_valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_WR(ID_WR), .flush(flush),
        .EX_Rs(ex_rs3), .EX_Rt(ex_rt3), .EX_RegWrite(ex_rw3), .EX_MemRead(ex_mr3), .EX_WR(ex_wr3),
        .M_RegWrite(m_rw3), .M_WR_out(m_wr3), .WB_RegWrite(wb_rw3), .WB_WR_out(wb_wr3),
        .PC_stall(pc_st3), .IFID_stall(ifid_st3), .IFID_flush(ifid_fl3)
`ifdef HAZ_STALL_CNT_EN
        , .stall_cnt(cnt3)
`endif
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packs the expected outputs. The single stall value covers both
    // PC_stall and IFID_stall, which must always agree.
    function automatic logic [31:0] obs(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic rw, input logic mr, input logic [4:0] wr,
                                        input logic mrw, input logic [4:0] mwr,
                                        input logic wrw, input logic [4:0] wwr,
                                        input logic st, input logic fl);
        return {rs, rt, rw, mr, wr, mrw, mwr, wrw, wwr, st, st, fl};
    endfunction

    // Drives one cycle of inputs just after the rising edge and queues the
    // expected outputs for that cycle.
    task automatic applyStimulus(input string name, input bit sel3, input logic r,
                                 input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic rw, input logic mr, input logic [4:0] wr,
                                 input logic fl, input bit chk, input logic [31:0] expv,
                                 input logic [15:0] exp_cnt);
        entry_t e;
        @(posedge clk);
        #1;
        rst         = r;
        ID_valid    = v;
        ID_Rs       = rs;
        ID_Rt       = rt;
        ID_RegWrite = rw;
        ID_MemRead  = mr;
        ID_WR       = wr;
        flush       = fl;
        e.name    = name;
        e.sel3    = sel3;
        e.chk     = chk;
        e.expv    = expv;
        e.exp_cnt = exp_cnt;
        sb.push_back(e);
    endtask

    // Compares one expected entry against the selected instance.
    task automatic checkOutput(input entry_t e);
        logic [31:0] act;
        if (e.sel3)
            act = {ex_rs3, ex_rt3, ex_rw3, ex_mr3, ex_wr3, m_rw3, m_wr3, wb_rw3, wb_wr3,
                   pc_st3, ifid_st3, ifid_fl3};
        else
            act = {ex_rs1, ex_rt1, ex_rw1, ex_mr1, ex_wr1, m_rw1, m_wr1, wb_rw1, wb_wr1,
                   pc_st1, ifid_st1, ifid_fl1};
        tests_run++;
        if (act !== e.expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.expv);
        end
`ifdef HAZ_STALL_CNT_EN
        tests_run++;
        if ((e.sel3 ? cnt3 : cnt1) !== e.exp_cnt) begin
            tests_failed++;
            $display("[TB] FAIL %s stall_cnt: got %0d expected %0d", e.name,
                     (e.sel3 ? cnt3 : cnt1), e.exp_cnt);
        end
`endif
    endtask

    // Monitor: pops one expectation per cycle and checks it away from the edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            entry_t e;
            e = sb.pop_front();
            if (e.chk) checkOutput(e);
        end
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        logic [31:0] z;
        z = obs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0; ID_valid = 1'b1; ID_Rs = 5'd3; ID_Rt = 5'd3;
        ID_RegWrite = 1'b1; ID_MemRead = 1'b1; ID_WR = 5'd3; flush = 1'b0;

        // Reset with random inputs, then release with ID idle.
        for (int i = 0; i < 2; i++)
            applyStimulus("reset_hold", 0, 0, 1'($urandom), 5'($urandom), 5'($urandom),
                          1'($urandom), 1'($urandom), 5'($urandom), 0, 1, z, 0);
        applyStimulus("reset_rel0", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, z, 0);
        applyStimulus("reset_rel1", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, z, 0);

        // Load-use with LOAD_STALL=1: lw r8 followed by add using r8.
        applyStimulus("lu_lw_id", 0, 1, 1, 2, 8, 1, 1, 8, 0, 1, z, 0);
        applyStimulus("lu_stall", 0, 1, 1, 8, 3, 1, 0, 10, 0, 1, obs(2, 8, 1, 1, 8, 0, 0, 0, 0, 1, 0), 0);
        applyStimulus("lu_bubble", 0, 1, 1, 8, 3, 1, 0, 10, 0, 1, obs(0, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0), 0);
        applyStimulus("lu_fwd_wb", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, obs(8, 3, 1, 0, 10, 0, 0, 1, 8, 0, 0), 0);
        applyStimulus("lu_drain0", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, obs(0, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0), 0);
        applyStimulus("lu_drain1", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, obs(0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0), 0);

        // Non-load dependency: add r9 then add reading r9; no stall.
        applyStimulus("nl_add0", 0, 1, 1, 1, 2, 1, 0, 9, 0, 1, z, 0);
        applyStimulus("nl_add1", 0, 1, 1, 4, 9, 1, 0, 11, 0, 1, obs(1, 2, 1, 0, 9, 0, 0, 0, 0, 0, 0), 0);
        applyStimulus("nl_fwd_m", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, obs(4, 9, 1, 0, 11, 1, 9, 0, 0, 0, 0), 0);
        applyStimulus("nl_drain0", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, obs(0, 0, 0, 0, 0, 1, 11, 1, 9, 0, 0), 0);
        applyStimulus("nl_drain1", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, obs(0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0), 0);

        // r0 guard: a load to r0 neither writes nor stalls.
        applyStimulus("r0_lw", 0, 1, 1, 3, 0, 1, 1, 0, 0, 1, z, 0);
        applyStimulus("r0_nostall", 0, 1, 1, 0, 4, 1, 0, 12, 0, 1, obs(3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0);
        applyStimulus("r0_add_ex", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, obs(0, 4, 1, 0, 12, 0, 0, 0, 0, 0, 0), 0);
        applyStimulus("r0_add_m", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, obs(0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0), 0);
        applyStimulus("r0_add_wb", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, obs(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0), 0);

        // Flush in the same cycle as a load-use hazard: flush wins.
        applyStimulus("fl_lw", 0, 1, 1, 1, 5, 1, 1, 5, 0, 1, z, 0);
        applyStimulus("fl_hazard", 0, 1, 1, 5, 6, 1, 0, 13, 1, 1, obs(1, 5, 1, 1, 5, 0, 0, 0, 0, 0, 1), 0);
        applyStimulus("fl_bubble", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, obs(0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0), 0);
        applyStimulus("fl_drain", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, obs(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0), 0);

        // LOAD_STALL=3 instance: start from a fresh reset.
        applyStimulus("ls3_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, z, 0);
        applyStimulus("ls3_lw", 1, 1, 1, 2, 7, 1, 1, 7, 0, 1, z, 0);
        applyStimulus("ls3_st1", 1, 1, 1, 1, 7, 1, 0, 14, 0, 1, obs(2, 7, 1, 1, 7, 0, 0, 0, 0, 1, 0), 0);
        applyStimulus("ls3_st2", 1, 1, 1, 1, 7, 1, 0, 14, 0, 1, obs(0, 0, 0, 0, 0, 1, 7, 0, 0, 1, 0), 1);
        applyStimulus("ls3_st3", 1, 1, 1, 1, 7, 1, 0, 14, 0, 1, obs(0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0), 2);
        applyStimulus("ls3_release", 1, 1, 1, 1, 7, 1, 0, 14, 0, 1, z, 3);
        applyStimulus("ls3_add_ex", 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, obs(1, 7, 1, 0, 14, 0, 0, 0, 0, 0, 0), 3);
        applyStimulus("ls3_add_m", 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, obs(0, 0, 0, 0, 0, 1, 14, 0, 0, 0, 0), 3);

        // Reset during the second stall cycle abandons the stall.
        applyStimulus("rs_lw", 1, 1, 1, 2, 7, 1, 1, 7, 0, 1, obs(0, 0, 0, 0, 0, 0, 0, 1, 14, 0, 0), 3);
        applyStimulus("rs_st1", 1, 1, 1, 7, 1, 1, 0, 15, 0, 1, obs(2, 7, 1, 1, 7, 0, 0, 0, 0, 1, 0), 3);
        applyStimulus("rs_st2_rst", 1, 0, 1, 7, 1, 1, 0, 15, 0, 1, obs(0, 0, 0, 0, 0, 1, 7, 0, 0, 1, 0), 4);
        applyStimulus("rs_after", 1, 1, 1, 7, 1, 1, 0, 15, 0, 1, z, 0);
        applyStimulus("rs_add_ex", 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, obs(7, 1, 1, 0, 15, 0, 0, 0, 0, 0, 0), 0);

        // Let the monitor drain, bounded to a few cycles.
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
        #1;
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
